// File: rtl/keypad_scanner.sv
// Column-scanning controller for a 4x4 active-low matrix keypad; one full snapshot per 4-column sweep.
// Optional build macro KEYPAD_SYNC_EN adds a 2-flop synchronizer on the row inputs (needs SETTLE_CYCLES >= 3).
module keypad_scanner #(
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    output logic [15:0] keys_pressed,
    output logic        scan_done
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } col_state_t;

    col_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       cols_nxt;
    logic [15:0]      work, work_nxt;
    logic [15:0]      keys_nxt;
    logic             done_nxt;
    logic [3:0]       rows_s;
    logic [3:0]       nib;

`ifdef KEYPAD_SYNC_EN
    logic [3:0] rows_meta;
    logic [3:0] rows_sync;

    // Idle rows read as all-high, so the synchronizer resets to "no key".
    always_ff @(posedge clk) begin
        if (!reset) begin
            rows_meta <= 4'b1111;
            rows_sync <= 4'b1111;
        end else begin
            rows_meta <= rows;
            rows_sync <= rows_meta;
        end
    end

    assign rows_s = rows_sync;
`else
    assign rows_s = rows;
`endif

    assign nib = ~rows_s;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        cols_nxt  = cols;
        work_nxt  = work;
        keys_nxt  = keys_pressed;
        done_nxt  = 1'b0;

        if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            unique case (state)
                COL0: begin
                    work_nxt[3:0] = nib;
                    state_nxt     = COL1;
                    cols_nxt      = 4'b1101;
                end
                COL1: begin
                    work_nxt[7:4] = nib;
                    state_nxt     = COL2;
                    cols_nxt      = 4'b1011;
                end
                COL2: begin
                    work_nxt[11:8] = nib;
                    state_nxt      = COL3;
                    cols_nxt       = 4'b0111;
                end
                COL3: begin
                    // The COL3 nibble is sampled on this same edge, so bypass it into the snapshot.
                    work_nxt[15:12] = nib;
                    state_nxt       = COL0;
                    cols_nxt        = 4'b1110;
                    keys_nxt        = {nib, work[11:0]};
                    done_nxt        = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= COL0;
            cnt          <= '0;
            cols         <= 4'b1110;
            // NOTE: the working register is reset so a sweep interrupted by reset never leaks stale nibbles.
            work         <= '0;
            keys_pressed <= '0;
            scan_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            cols         <= cols_nxt;
            work         <= work_nxt;
            keys_pressed <= keys_nxt;
            scan_done    <= done_nxt;
        end
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Column-scanning controller for the 4x4 matrix keypad. Drives one column low at a time, waits a settle interval, samples the four active-low row lines, and assembles a 16-bit snapshot of all pressed keys once per full sweep. Sits between the keypad pins and the jitter controller: `keys_pressed` feeds the debouncer's key input directly, and `scan_done` marks each refreshed snapshot.

## Interface
- `SETTLE_CYCLES`, default 1000: clock cycles each column is held before its rows are sampled. Minimum 1, or 3 when `KEYPAD_SYNC_EN` is defined.
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-low.
- `rows` in 4: keypad row lines, active-low (external pull-ups), asynchronous to `clk`.
- `cols` out 4: column drive, active-low; exactly one bit low at all times.
- `keys_pressed` out 16: last complete snapshot, active-high; bit `4*c + r` is set when column c / row r is pressed.
- `scan_done` out 1: one-cycle pulse when `keys_pressed` updates.

## Operation
- States: COL0, COL1, COL2, COL3, in that fixed cyclic order.
- `cols` per state: COL0 4'b1110, COL1 4'b1101, COL2 4'b1011, COL3 4'b0111.
- Settle counter:
  - Width `$clog2(SETTLE_CYCLES)`, minimum 1 bit.
  - Counts 0..SETTLE_CYCLES-1 in each state.
  - Clears to 0 on every state change.
- Sample: on the edge where the counter equals SETTLE_CYCLES-1:
  - Write `~rows_s` into working register bits [4c+3:4c].
  - Advance to the next state.
  - `rows_s` is the synchronized or raw row value, as selected under Configuration.
- Snapshot: on the COL3 sample edge:
  - Load `keys_pressed` with the working register, with the COL3 nibble replaced by the value sampled on that same edge.
  - Assert `scan_done` for that one cycle.
  - The working register is not cleared; every nibble is overwritten each sweep.
- Multiple simultaneous keys are all reported. Ghosting is not resolved here.
- Reset (synchronous, low on a rising edge) is honoured in any state, including mid-column:
  - State returns to COL0 and the counter to 0.
  - The partial sweep is discarded and the working register clears.
- Reset values:
  - `cols` = 4'b1110, `keys_pressed` = 16'h0000, `scan_done` = 0.
  - Working register 0, synchronizer flops 4'b1111 when present.

## Timing
- Cycle numbering: edge 1 is the first rising edge with `reset` high.
- `cols` changes on edges S, 2S, 3S, 4S, … (S = SETTLE_CYCLES). Each column is driven for exactly S cycles.
- `keys_pressed` and `scan_done` are registered:
  - They update at edge 4S and then every 4S edges.
  - `scan_done` is high in the cycle following each such edge and low otherwise.
- Row-to-snapshot latency:
  - Sample for column c is taken at edge (c+1)·S within the sweep.
  - With sync enabled, the row value must be stable for the 2 cycles before that sample edge.
- With S = 1, columns advance every cycle and `scan_done` pulses every 4 cycles; this is legal only without sync.
- Outputs are glitch-free: all are direct flop outputs.

## Configuration
- `KEYPAD_SYNC_EN` defined:
  - `rows` passes through a 2-flop synchronizer, reset to 4'b1111, before sampling.
  - Requires SETTLE_CYCLES ≥ 3 so the sampled value reflects the currently driven column.
- Not defined:
  - `rows` is sampled directly at the sample edge with zero added latency. This mode is for simulation or externally synchronized inputs.
- Ports, state sequence and output timing are identical in both builds.

## Test plan
All scenarios use SETTLE_CYCLES = 4, both with and without `KEYPAD_SYNC_EN`. The keypad model pulls row r low while the column of a pressed key is low.
- Reset held for 3 cycles with rows = 4'b0000 → `cols` = 4'b1110, `keys_pressed` = 16'h0000, `scan_done` = 0 throughout.
- No keys (rows = 4'b1111):
  - `cols` steps 1110→1101→1011→0111→1110, 4 cycles each.
  - `scan_done` pulses once every 16 cycles, first at edge 16.
  - `keys_pressed` stays 16'h0000.
- Key at column 2, row 1 → `keys_pressed` = 16'h0200 at the first `scan_done`, unchanged on subsequent sweeps.
- Keys at column 0 row 0 and column 3 row 3 → `keys_pressed` = 16'h8001. Releasing both → 16'h0000 at the next `scan_done`.
- Key at column 1 row 2 held, then reset asserted during COL2 →
  - Next cycle: `cols` = 4'b1110, `keys_pressed` = 16'h0000.
  - After release: next `scan_done` occurs exactly 16 cycles later with `keys_pressed` = 16'h0040.
- Key at column 3 row 0 pressed only during COL3 of one sweep → that sweep reports 16'h1000 and the following sweep reports 16'h0000.
